// File: rtl/class_seq_ctrl.sv
// Job sequencer in front of gen_class: queues train/predict jobs, inserts class-HV overrides,
// issues one job at a time, waits for gc_done with a timeout, and holds predictions until consumed.
module class_seq_ctrl #(
  parameter int DIMENSIONS = 10000,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 65535
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIMENSIONS-1:0] in_hv,
  input  logic                  in_op,
  input  logic                  in_label,
  input  logic                  cfg_load,
  input  logic [DIMENSIONS-1:0] cfg_hv_ns,
  input  logic [DIMENSIONS-1:0] cfg_hv_sz,
  output logic                  gc_en,
  output logic [DIMENSIONS-1:0] gc_window_hv,
  output logic                  gc_op,
  output logic                  gc_label_train,
  output logic                  gc_label_override,
  output logic [DIMENSIONS-1:0] gc_override_hv_nonseizure,
  output logic [DIMENSIONS-1:0] gc_override_hv_seizure,
  input  logic                  gc_done,
  input  logic                  gc_label_predict,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  res_label,
  output logic                  busy,
  output logic                  err_timeout,
  output logic [15:0]           cnt_train,
  output logic [15:0]           cnt_pred
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int EW = DIMENSIONS + 2;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_OVR, S_ISSUE, S_WAIT, S_RESULT} state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, full_d;
  logic                  job_op_q, job_op_d, job_label_q, job_label_d;
  logic [DIMENSIONS-1:0] job_hv_q, job_hv_d;
  logic                  cfg_pend_q, cfg_pend_d;
  logic [DIMENSIONS-1:0] cfg_ns_q, cfg_ns_d, cfg_sz_q, cfg_sz_d;
  logic [TW-1:0]         tmo_cnt_q, tmo_cnt_d;
  logic                  err_q, err_d;
  logic                  res_valid_q, res_valid_d, res_label_q, res_label_d;
  logic [15:0]           cnt_train_q, cnt_train_d, cnt_pred_q, cnt_pred_d;
  logic                  push, pop;
  logic [EW-1:0]         head;
  logic [EW-1:0]         fifo_mem_q [FIFO_DEPTH];

  // full_q is registered so in_ready never depends on a same-cycle pop
  assign push = in_valid && !full_q;
  assign head = fifo_mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {in_op, in_label, in_hv};
  end

  always_comb begin
    state_d     = state_q;
    job_op_d    = job_op_q;
    job_label_d = job_label_q;
    job_hv_d    = job_hv_q;
    cfg_pend_d  = cfg_pend_q;
    cfg_ns_d    = cfg_ns_q;
    cfg_sz_d    = cfg_sz_q;
    tmo_cnt_d   = tmo_cnt_q;
    err_d       = err_q;
    res_valid_d = res_valid_q;
    res_label_d = res_label_q;
    cnt_train_d = cnt_train_q;
    cnt_pred_d  = cnt_pred_q;
    pop         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cfg_pend_q) begin
          state_d = S_OVR;
        end else if (count_q != '0) begin
          pop         = 1'b1;
          job_op_d    = head[EW-1];
          job_label_d = head[EW-2];
          job_hv_d    = head[DIMENSIONS-1:0];
          state_d     = S_ISSUE;
        end
      end
      S_OVR: begin
        cfg_pend_d = 1'b0;
        state_d    = S_IDLE;
      end
      S_ISSUE: begin
        tmo_cnt_d = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (gc_done) begin
          if (job_op_q) begin
            res_valid_d = 1'b1;
            res_label_d = gc_label_predict;
            state_d     = S_RESULT;
          end else begin
            if (cnt_train_q != 16'hFFFF) cnt_train_d = cnt_train_q + 16'd1;
            state_d = S_IDLE;
          end
        end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
          // this is the TIMEOUT-th WAIT cycle without completion: drop the job
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      S_RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (cnt_pred_q != 16'hFFFF) cnt_pred_d = cnt_pred_q + 16'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // a load arriving in the OVR cycle re-arms the override with the new values
    if (cfg_load) begin
      cfg_pend_d = 1'b1;
      cfg_ns_d   = cfg_hv_ns;
      cfg_sz_d   = cfg_hv_sz;
    end

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == CW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      job_op_q    <= 1'b0;
      job_label_q <= 1'b0;
      job_hv_q    <= '0;
      cfg_pend_q  <= 1'b0;
      cfg_ns_q    <= '0;
      cfg_sz_q    <= '0;
      tmo_cnt_q   <= '0;
      err_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_label_q <= 1'b0;
      cnt_train_q <= '0;
      cnt_pred_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      job_op_q    <= job_op_d;
      job_label_q <= job_label_d;
      job_hv_q    <= job_hv_d;
      cfg_pend_q  <= cfg_pend_d;
      cfg_ns_q    <= cfg_ns_d;
      cfg_sz_q    <= cfg_sz_d;
      tmo_cnt_q   <= tmo_cnt_d;
      err_q       <= err_d;
      res_valid_q <= res_valid_d;
      res_label_q <= res_label_d;
      cnt_train_q <= cnt_train_d;
      cnt_pred_q  <= cnt_pred_d;
    end
  end

  assign in_ready                  = !full_q;
  assign gc_en                     = (state_q == S_ISSUE);
  assign gc_window_hv              = job_hv_q;
  assign gc_op                     = job_op_q;
  assign gc_label_train            = job_label_q;
  assign gc_label_override         = (state_q == S_OVR);
  assign gc_override_hv_nonseizure = (state_q == S_OVR) ? cfg_ns_q : '0;
  assign gc_override_hv_seizure    = (state_q == S_OVR) ? cfg_sz_q : '0;
  assign res_valid                 = res_valid_q;
  assign res_label                 = res_label_q;
  assign busy                      = (state_q != S_IDLE) || (count_q != '0);
  assign err_timeout               = err_q;
  assign cnt_train                 = cnt_train_q;
  assign cnt_pred                  = cnt_pred_q;

endmodule
